// File: rtl/updown_bcd_scan_pkg.sv
// rtl/updown_bcd_scan_pkg.sv - shared BCD types, segment patterns and direction codes
package updown_pkg;

    typedef logic [3:0] bcd_t;

    // Segment patterns, bit 0 = a ... bit 6 = g, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // Non-decimal nibbles are forced to zero on load
    function automatic bcd_t bcd_clean(bcd_t d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/updown_bcd_scan_if.sv
// rtl/updown_bcd_scan_if.sv - control and display bundle for the BCD scan counter
interface updown_bcd_scan_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  ud;
    logic                  sat;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     digit;

    modport master (
        output en, ud, sat, load, load_val,
        input  count, tc, seg, digit
    );

    modport slave (
        input  en, ud, sat, load, load_val,
        output count, tc, seg, digit
    );
endinterface

// File: rtl/updown_bcd_scan_seg7_decode.sv
// rtl/updown_bcd_scan_seg7_decode.sv - BCD nibble to 7-segment pattern
module seg7_decode
    import updown_pkg::*;
(
    input  bcd_t       nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/updown_bcd_scan.sv
// rtl/updown_bcd_scan.sv - multi-digit BCD up/down counter with multiplexed 7-segment scan
module updown_bcd_scan
    import updown_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic               clk,
    input  logic               rst,
    updown_bcd_scan_if.slave   bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [4*DIGITS-1:0] count_r;
    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_clean;
    bcd_t                digit_arr [DIGITS];
    logic                tc_r;
    logic                boundary;

    // Ripple chain: a digit moves only when every lower digit sits at its edge value
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_t d;
        bcd_t nd;
        logic cin;
        logic cout;
        logic at_edge;

        if (i == 0) begin : g_lsd
            assign cin = 1'b1;
        end else begin : g_upper
            assign cin = g_digit[i-1].cout;
        end

        assign d       = count_r[4*i +: 4];
        assign at_edge = (bus.ud == UP) ? (d == 4'd9) : (d == 4'd0);
        assign cout    = cin & at_edge;

        always_comb begin
            nd = d;
            if (cin) begin
                if (at_edge)
                    nd = (bus.ud == UP) ? 4'd0 : 4'd9;
                else
                    nd = (bus.ud == UP) ? d + 4'd1 : d - 4'd1;
            end
        end

        assign step_val[4*i +: 4]   = nd;
        assign load_clean[4*i +: 4] = bcd_clean(bus.load_val[4*i +: 4]);
        assign digit_arr[i]         = d;
    end

    assign boundary = g_digit[DIGITS-1].cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            tc_r    <= 1'b0;
        end else if (bus.load) begin
            count_r <= load_clean;
            tc_r    <= 1'b0;
        end else if (bus.en) begin
            tc_r <= boundary;
            if (!(boundary && bus.sat))
                count_r <= step_val;
        end else begin
            tc_r <= 1'b0;
        end
    end

    logic [CNT_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  idx_next;
    logic              scan_wrap;
    bcd_t              sel_nibble;
    logic [6:0]        seg_next;
    logic [6:0]        seg_r;
    logic [DIGITS-1:0] digit_r;

    assign scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        idx_next = scan_idx;
        if (scan_wrap)
            idx_next = (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end

    // Decoding at the upcoming index keeps seg and digit describing the same position
    assign sel_nibble = digit_arr[idx_next];

    seg7_decode u_seg7_decode (
        .nibble (sel_nibble),
        .seg    (seg_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            digit_r  <= DIGITS'(1);
            seg_r    <= SEG_0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + CNT_W'(1);
            scan_idx <= idx_next;
            digit_r  <= DIGITS'(1) << idx_next;
            seg_r    <= seg_next;
        end
    end

    assign bus.count = count_r;
    assign bus.tc    = tc_r;
    assign bus.seg   = seg_r;
    assign bus.digit = digit_r;

endmodule

// File: doc/updown_bcd_scan.md
# updown_bcd_scan

Parametrised multi-digit BCD up/down counter with load, selectable wrap/saturate behaviour and a time-multiplexed 7-segment display driver. It is the next generation of the single-digit up/down counter with 7-segment output. It sits between board-level controls (enable, direction, load) and the board's shared-segment display, and also exposes the raw BCD count to downstream logic.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits (1..8)
- SCAN_DIV, 16, clock cycles each digit stays selected (≥1)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  count enable; one step per cycle while high
- ud  input  1  direction: 1 = up, 0 = down
- sat  input  1  boundary mode: 1 = saturate, 0 = wrap
- load  input  1  synchronous load of load_val
- load_val  input  4*DIGITS  BCD load value; digit 0 in bits [3:0]
- count  output  4*DIGITS  current BCD count; digit 0 = least significant
- tc  output  1  terminal-count pulse
- seg  output  7  segments, active-high, seg[0]=a … seg[6]=g
- digit  output  DIGITS  one-hot digit select, active-high

## Operation
- Priority each cycle: rst > load > en > hold.
- Load:
  - count <= load_val.
  - Any nibble > 9 loads as 0.
  - tc = 0 on a load cycle.
- Up step:
  - Digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
  - At all-9s with sat=0: wraps to 0, tc=1.
  - At all-9s with sat=1: count holds, tc=1.
- Down step:
  - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - At 0 with sat=0: wraps to all-9s, tc=1.
  - At 0 with sat=1: count holds, tc=1.
- tc is 0 in every other cycle, including en=0.
- ud and sat are sampled every cycle; a direction change takes effect on the next step with no dead cycle.
- Scan:
  - Free-running counter scan_cnt counts 0..SCAN_DIV-1 independently of en and load.
  - On wrap of scan_cnt, the digit index advances by 1, wrapping DIGITS-1 → 0.
  - digit = one-hot of the index.
  - seg = 7-segment decode of the count nibble at the index.
- Decode values (g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any other nibble = 00.

## Timing
- All outputs are registered.
- Reset values: count=0, tc=0, scan index=0, scan_cnt=0, digit=1 (digit 0 selected), seg=7'h3F.
- count: new value visible the cycle after the edge that samples en/load.
- tc: asserted in the same cycle the wrapped or held boundary value is presented, for exactly 1 cycle per boundary step.
- Repeated boundary steps: with sat=1 and en held high at the boundary, tc stays high every cycle.
- seg lags count by 1 cycle; seg is computed from the registered count and registered scan index.
- digit and seg change on the same edge.
- Each digit stays selected for exactly SCAN_DIV cycles.
- Full scan period = DIGITS*SCAN_DIV cycles.
- rst mid-operation: all state, including scan position, returns to reset values on the next edge regardless of load/en.
- load and en high in the same cycle: load wins, no step taken.

## Structure
- Package updown_pkg:
  - BCD digit typedef (4-bit).
  - The ten segment constants and the blank constant.
  - Direction encodings UP=1, DOWN=0.
- One sub-module, seg7_decode: combinational nibble → 7-bit segment map, used once on the selected nibble.
- Carry/borrow chain: a generate loop over DIGITS inside the top module.
- No sub-module for the digit cell.

## Test plan
Bench configuration: DIGITS=2, SCAN_DIV=4.
- Reset state:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: count=8'h00, tc=0, digit=2'b01, seg=7'h3F; digit becomes 2'b10 after 4 cycles, then back to 2'b01 after 4 more.
- Up wrap:
  - Stimulus: load 8'h98; en=1, ud=1, sat=0.
  - Required: count 99 → 00; tc=1 only in the cycle count=00; next cycle count=01.
- Down saturate:
  - Stimulus: load 8'h01; en=1, ud=0, sat=1 for 4 cycles.
  - Required: count 00 held; tc=1 for the 3 cycles after 00 is reached; tc=0 on the 01 → 00 step.
- Load priority and invalid BCD:
  - Stimulus: load=1, en=1, load_val=8'hA7.
  - Required: count=8'h07, tc=0.
- Direction change and scan decode:
  - Stimulus: from 8'h10 step down once, then up twice.
  - Required: count 09, 10, 11.
  - With count=8'h42 stable: seg=7'h5B while digit=01, seg=7'h66 while digit=10.
- Reset mid-count:
  - Stimulus: assert rst while en=1 and load=1.
  - Required: next edge gives count=00, tc=0, digit=01, seg=3F.
